// File: rtl/activation_pkg.sv
// activation_pkg
//   Shared definitions for the activation stages.
//   lut_state_e : control states of the programmable lookup table.
//   LUT_DEPTH   : number of table entries for a given input code width.
package activation_pkg;

  typedef enum logic [1:0] {
    LUT_LOAD  = 2'd0,
    LUT_RUN   = 2'd1,
    LUT_DRAIN = 2'd2
  } lut_state_e;

  function automatic int LUT_DEPTH(input int in_width);
    return 1 << in_width;
  endfunction

endpackage

// File: rtl/lut_ram_sdp.sv
// lut_ram_sdp
//   Simple dual-port RAM: one write port, one read port with a registered
//   output. The storage array has no reset so it maps onto block RAM.
//   Ports:
//     clk          clock, rising edge
//     we/waddr/wdata  write port
//     re/raddr     read enable / address; rdata updates only when re=1
//     rdata        registered read data (old data on same-address write)
module lut_ram_sdp #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    // Read register only advances on a read, so it doubles as the
    // holding register while the consumer stalls.
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/activation_lut_ram.sv
// activation_lut_ram
//   Programmable RAM-backed activation lookup table. A full table of output
//   codes is written through the program port, then input codes stream
//   through the lookup port and come out as table[code] one cycle later.
//   Ports:
//     clk, rst                      clock; synchronous active-low reset
//     prog_data/valid/ready         table write stream (LUT_LOAD only)
//     reload                        pulse in LUT_RUN: drain, then reprogram
//     lut_loaded                    table complete, lookups enabled
//     data_in_0/valid/ready         lookup codes (raw bits = table index)
//     data_out_0/valid/ready        looked-up output codes
module activation_lut_ram
  import activation_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = 8,
  parameter int DATA_IN_0_PRECISION_1  = 4,
  parameter int DATA_OUT_0_PRECISION_0 = 8,
  parameter int DATA_OUT_0_PRECISION_1 = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_OUT_0_PRECISION_0-1:0] prog_data,
  input  logic                              prog_valid,
  output logic                              prog_ready,
  input  logic                              reload,
  output logic                              lut_loaded,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int AW    = DATA_IN_0_PRECISION_0;
  localparam int DW    = DATA_OUT_0_PRECISION_0;
  localparam int DEPTH = LUT_DEPTH(DATA_IN_0_PRECISION_0);

  // Fraction widths only describe the fixed-point format; reject nonsense.
  generate
    if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0 ||
        DATA_OUT_0_PRECISION_1 > DATA_OUT_0_PRECISION_0) begin : g_bad_frac
      $error("activation_lut_ram: fraction width exceeds code width");
    end
  endgenerate

  lut_state_e    state_reg, state_next;
  logic [AW-1:0] wptr_reg, wptr_next;
  logic          out_valid_reg, out_valid_next;
  logic          prog_fire, lookup_fire;
  logic [DW-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= LUT_LOAD;
      wptr_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wptr_reg      <= wptr_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wptr_next       = wptr_reg;
    out_valid_next  = out_valid_reg;
    prog_ready      = 1'b0;
    lut_loaded      = 1'b0;
    data_in_0_ready = 1'b0;
    prog_fire       = 1'b0;
    lookup_fire     = 1'b0;

    // Handshake outputs are gated by rst so nothing is accepted while the
    // reset is being applied, whatever state the register still holds.
    case (state_reg)
      LUT_LOAD: begin
        prog_ready = rst;
      end
      LUT_RUN: begin
        lut_loaded      = rst;
        data_in_0_ready = rst && (!out_valid_reg || data_out_0_ready);
        // A lookup accepted alongside reload still lands in the output
        // register; LUT_DRAIN waits for it to be consumed.
        if (reload) begin
          state_next = LUT_DRAIN;
        end
      end
      LUT_DRAIN: begin
        lut_loaded = rst;
        if (!out_valid_reg) begin
          state_next = LUT_LOAD;
          wptr_next  = '0;
        end
      end
      default: begin
        state_next = LUT_LOAD;
        wptr_next  = '0;
      end
    endcase

    prog_fire   = prog_valid && prog_ready;
    lookup_fire = data_in_0_valid && data_in_0_ready;

    if (prog_fire) begin
      // Natural wrap of wptr brings it back to 0 after the last entry.
      wptr_next = wptr_reg + 1'b1;
      if (wptr_reg == AW'(DEPTH - 1)) begin
        state_next = LUT_RUN;
      end
    end

    if (lookup_fire) begin
      out_valid_next = 1'b1;
    end else if (data_out_0_ready) begin
      out_valid_next = 1'b0;
    end
  end

  lut_ram_sdp #(
    .DEPTH (DEPTH),
    .WIDTH (DW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (prog_fire),
    .waddr (wptr_reg),
    .wdata (prog_data),
    .re    (lookup_fire),
    .raddr (data_in_0),
    .rdata (rd_data)
  );

  // The RAM read register has no reset; masking gives a clean 0 whenever
  // no word is presented (reset, discarded in-flight output).
  assign data_out_0       = out_valid_reg ? rd_data : '0;
  assign data_out_0_valid = out_valid_reg;

endmodule

// File: tb/tb_activation_lut_ram.sv
module tb_activation_lut_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] prog_data = '0;
  logic       prog_valid = 1'b0;
  logic       prog_ready;
  logic       reload = 1'b0;
  logic       lut_loaded;
  logic [7:0] data_in_0 = '0;
  logic       data_in_0_valid = 1'b0;
  logic       data_in_0_ready;
  logic [7:0] data_out_0;
  logic       data_out_0_valid;
  logic       data_out_0_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference table: what the spec says mem[] holds after the writes made.
  logic [7:0] model [256];

  always #5 clk = ~clk;

  activation_lut_ram #(
    .DATA_IN_0_PRECISION_0  (8),
    .DATA_IN_0_PRECISION_1  (4),
    .DATA_OUT_0_PRECISION_0 (8),
    .DATA_OUT_0_PRECISION_1 (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .prog_data        (prog_data),
    .prog_valid       (prog_valid),
    .prog_ready       (prog_ready),
    .reload           (reload),
    .lut_loaded       (lut_loaded),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tval(input int kind, input int i);
    logic [7:0] b;
    b = i[7:0];
    case (kind)
      0:       return b;
      1:       return ~b;
      2:       return b + 8'd1;
      default: return b * 8'd7 + 8'd3;
    endcase
  endfunction

  task automatic write_words(input int kind, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        prog_valid = 1'b0;
        tick();
      end
      prog_data  = tval(kind, i);
      prog_valid = 1'b1;
      if (i == 255) begin
        data_in_0       = 8'h11;
        data_in_0_valid = 1'b1;
      end
      #1;
      chk("load_prog_ready", prog_ready, 1);
      chk("load_not_yet_loaded", lut_loaded, 0);
      if (i == 255) chk("final_write_in_ready", data_in_0_ready, 0);
      model[i] = tval(kind, i);
      tick();
    end
    prog_valid      = 1'b0;
    data_in_0_valid = 1'b0;
    if (first + count == 256) begin
      chk("loaded_after_final", lut_loaded, 1);
      chk("no_lookup_on_final", data_out_0_valid, 0);
      $display("load kind=%0d complete lut_loaded=%0b", kind, lut_loaded);
    end
  endtask

  // Back-to-back lookups with the consumer always ready.
  task automatic burst(input logic [7:0] cs[$]);
    data_out_0_ready = 1'b1;
    for (int i = 0; i < cs.size(); i++) begin
      data_in_0       = cs[i];
      data_in_0_valid = 1'b1;
      #1;
      chk("lk_in_ready", data_in_0_ready, 1);
      tick();
      chk("lk_valid", data_out_0_valid, 1);
      chk("lk_data", data_out_0, model[cs[i]]);
      $display("lookup in=%02h out=%02h exp=%02h", cs[i], data_out_0, model[cs[i]]);
    end
    data_in_0_valid = 1'b0;
  endtask

  task automatic do_reload();
    int n;
    data_out_0_ready = 1'b1;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    n = 0;
    while (!prog_ready && n < 20) begin
      tick();
      n++;
    end
    chk("reload_prog_ready", prog_ready, 1);
    chk("reload_lut_loaded", lut_loaded, 0);
    $display("reload prog_ready=%0b lut_loaded=%0b", prog_ready, lut_loaded);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] codes[16];
    logic [7:0] exp_q[$];
    logic [7:0] held, popped;
    logic       stalled;
    int         sent, got, cyc;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_prog_ready", prog_ready, 0);
    chk("rst_lut_loaded", lut_loaded, 0);
    chk("rst_in_ready", data_in_0_ready, 0);
    chk("rst_out_valid", data_out_0_valid, 0);
    chk("rst_out_data", data_out_0, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_prog_ready", prog_ready, 1);
    $display("reset released prog_ready=%0b", prog_ready);

    // ---- identity load and lookups ----
    write_words(0, 0, 256);
    q = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    burst(q);
    tick();
    chk("idle_after_burst", data_out_0_valid, 0);

    // ---- index wrap with inverted table ----
    do_reload();
    write_words(1, 0, 256);
    q = '{8'hFF};
    burst(q);
    chk("wrap_minus1", data_out_0, 8'h00);
    q = '{8'h00};
    burst(q);
    chk("wrap_zero", data_out_0, 8'hFF);
    tick();

    // ---- backpressure stream ----
    foreach (codes[i]) codes[i] = 8'($urandom_range(0, 255));
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < 16 && cyc < 400) begin
      if (stalled) begin
        chk("bp_hold_valid", data_out_0_valid, 1);
        chk("bp_hold_data", data_out_0, held);
      end
      data_in_0_valid  = (sent < 16) && ($urandom_range(0, 3) != 0);
      data_in_0        = (sent < 16) ? codes[sent] : 8'h00;
      data_out_0_ready = 1'($urandom_range(0, 1));
      #1;
      chk("bp_in_ready", data_in_0_ready, !data_out_0_valid || data_out_0_ready);
      if (data_out_0_valid && data_out_0_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_unexpected_valid", data_out_0_valid, 0);
        end else begin
          popped = exp_q.pop_front();
          chk("bp_data", data_out_0, popped);
          $display("bp out=%02h exp=%02h", data_out_0, popped);
        end
        got++;
      end
      stalled = data_out_0_valid && !data_out_0_ready;
      held    = data_out_0;
      if (data_in_0_valid && data_in_0_ready) begin
        exp_q.push_back(model[data_in_0]);
        sent++;
      end
      tick();
      cyc++;
    end
    data_in_0_valid = 1'b0;
    chk("bp_received", got, 16);
    chk("bp_sent", sent, 16);
    chk("bp_no_dup", data_out_0_valid, 0);

    // ---- reload with a lookup accepted in the same cycle ----
    data_out_0_ready = 1'b0;
    data_in_0        = 8'h09;
    data_in_0_valid  = 1'b1;
    reload           = 1'b1;
    #1;
    chk("rl_accept_ready", data_in_0_ready, 1);
    tick();
    reload = 1'b0;
    data_in_0_valid = 1'b0;
    chk("rl_pending_valid", data_out_0_valid, 1);
    chk("rl_pending_data", data_out_0, model[9]);
    chk("rl_drain_prog_ready", prog_ready, 0);
    tick();
    chk("rl_stall_valid", data_out_0_valid, 1);
    chk("rl_stall_data", data_out_0, model[9]);
    data_out_0_ready = 1'b1;
    data_in_0        = 8'h05;
    data_in_0_valid  = 1'b1;
    #1;
    chk("rl_drain_in_ready", data_in_0_ready, 0);
    tick();
    data_in_0_valid = 1'b0;
    chk("rl_consumed", data_out_0_valid, 0);
    cyc = 0;
    while (!prog_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("rl_prog_ready", prog_ready, 1);
    chk("rl_lut_loaded", lut_loaded, 0);
    write_words(2, 0, 256);
    q = '{8'h05};
    burst(q);
    chk("rl_lookup5", data_out_0, 8'h06);
    tick();

    // ---- reset in the middle of a load ----
    do_reload();
    write_words(3, 0, 100);
    rst = 1'b0;
    tick();
    chk("mid_rst_prog_ready", prog_ready, 0);
    chk("mid_rst_lut_loaded", lut_loaded, 0);
    chk("mid_rst_in_ready", data_in_0_ready, 0);
    chk("mid_rst_out_valid", data_out_0_valid, 0);
    chk("mid_rst_out_data", data_out_0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_release", prog_ready, 1);
    $display("mid-load reset done");
    tick();
    write_words(0, 0, 256);
    q = '{8'h00, 8'h32, 8'h63, 8'h64, 8'h96, 8'hFF};
    burst(q);
    tick();

    // ---- programming ignored while running ----
    prog_data  = 8'hAA;
    prog_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("run_prog_ready", prog_ready, 0);
      tick();
    end
    prog_valid = 1'b0;
    q = '{8'h03, 8'h00, 8'hFF};
    burst(q);
    tick();

    // ---- reset discards an in-flight output ----
    data_out_0_ready = 1'b0;
    data_in_0        = 8'h42;
    data_in_0_valid  = 1'b1;
    tick();
    data_in_0_valid = 1'b0;
    chk("inflight_valid", data_out_0_valid, 1);
    chk("inflight_data", data_out_0, 8'h42);
    rst = 1'b0;
    tick();
    chk("inflight_rst_valid", data_out_0_valid, 0);
    chk("inflight_rst_data", data_out_0, 0);
    chk("inflight_rst_loaded", lut_loaded, 0);
    rst = 1'b1;
    #1;
    chk("inflight_rst_prog_ready", prog_ready, 1);
    $display("in-flight reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/activation_lut_ram.md
# activation_lut_ram

Programmable, RAM-backed activation lookup table with streaming valid/ready ports. A program port writes a full table of output codes, and a lookup port then streams input codes through the table. This replaces hard-coded per-function case LUTs such as the ELU table, so one block serves any elementwise activation. It sits inside activation stages between the producing linear/conv stream and the consumer.

## Interface
- DATA_IN_0_PRECISION_0, 8: input code width; the table depth is 2**DATA_IN_0_PRECISION_0.
- DATA_IN_0_PRECISION_1, 4: input fraction bits; documentation only, no effect on indexing.
- DATA_OUT_0_PRECISION_0, 8: output and table word width.
- DATA_OUT_0_PRECISION_1, 4: output fraction bits; documentation only.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- prog_data  in  DATA_OUT_0_PRECISION_0  next table word.
- prog_valid  in  1  prog_data valid.
- prog_ready  out  1  table accepting writes.
- reload  in  1  single-cycle pulse that requests reprogramming.
- lut_loaded  out  1  table complete, lookups enabled.
- data_in_0  in  DATA_IN_0_PRECISION_0  lookup code; its raw bits are the table index.
- data_in_0_valid  in  1
- data_in_0_ready  out  1
- data_out_0  out  DATA_OUT_0_PRECISION_0  table[data_in_0].
- data_out_0_valid  out  1
- data_out_0_ready  in  1

## Operation
- **States:**
  - LUT_LOAD: entered from reset and from LUT_DRAIN.
  - LUT_RUN: lookups enabled.
  - LUT_DRAIN: flushes the output register before reload.
- **LUT_LOAD:**
  - prog_ready=1 and data_in_0_ready=0.
  - Each prog_valid&&prog_ready cycle writes mem[wptr]=prog_data, then increments wptr.
  - The write with wptr==DEPTH-1 is the final write. It wraps wptr to 0 and moves to LUT_RUN.
  - There is no partial-load exit.
- **LUT_RUN:**
  - prog_ready=0, and prog_valid is ignored (no write, no error).
  - lut_loaded=1.
  - data_in_0_ready = !data_out_0_valid || data_out_0_ready.
  - On accept, the RAM read of mem[data_in_0] is registered and lands in data_out_0 with data_out_0_valid=1.
- **Output register:**
  - data_out_0 and data_out_0_valid hold stable while data_out_0_valid && !data_out_0_ready.
  - valid clears only when the word is consumed with no new accept in the same cycle.
- **reload in LUT_RUN:**
  - Move to LUT_DRAIN and deassert data_in_0_ready immediately in that cycle's next state.
  - A lookup accepted in the same cycle as reload still completes.
- **LUT_DRAIN:**
  - Wait until !data_out_0_valid, then go to LUT_LOAD with wptr=0 and lut_loaded=0.
  - Old table contents remain until overwritten.
- reload is ignored in LUT_LOAD and LUT_DRAIN.
- **Indexing:** the index is the unsigned reinterpretation of the input bits. Two's-complement −1 maps to DEPTH-1. No saturation or arithmetic is applied.

## Timing
- **Reset (rst==0 at an edge):**
  - state=LUT_LOAD, wptr=0.
  - prog_ready=0 during the reset cycle, 1 from the first cycle after reset release.
  - lut_loaded=0, data_in_0_ready=0, data_out_0_valid=0, data_out_0=0.
  - RAM contents are undefined after reset.
- **Reset mid-operation:** any state returns to LUT_LOAD, and an in-flight output is discarded.
- **Lookup latency:** exactly 1 cycle, from the accept edge to data_out_0_valid.
- **Throughput:** 1 lookup/cycle with data_out_0_ready held high.
- **Load time:** DEPTH accepted writes. lut_loaded rises on the cycle after the final write.
- **Simultaneous events:**
  - The final write and an incoming data_in_0_valid in the same cycle do not produce a lookup; ready is 0 in LUT_LOAD.
  - The first lookup may be accepted in the cycle lut_loaded=1.

## Structure
- **Shared activation package (`activation_pkg`):**
  - `lut_state_e` enum with LUT_LOAD, LUT_RUN, LUT_DRAIN.
  - A `LUT_DEPTH` function of the input width.
- **Sub-module `lut_ram_sdp`:**
  - Simple dual-port RAM: one write port and one registered read port, depth/width parameters.
  - No reset on the storage array.
- The top holds the FSM, wptr counter, handshake logic and output register.

## Test plan
- **Identity load:** width 8/8, program mem[i]=i.
  - lut_loaded rises the cycle after the 256th write.
  - Lookups 0x00, 0x7F, 0x80, 0xFF return the same values, each 1 cycle after accept.
- **Index wrap:** program mem[i]=~i, then look up 0xFF (−1) and 0x00.
  - Outputs must be 0x00 and 0xFF, with no saturation.
- **Backpressure:** stream 16 random codes with data_out_0_ready toggling randomly.
  - Output order and values must match a reference model.
  - data_out_0 is stable while stalled, and nothing is lost or duplicated.
- **Reload mid-stream:** assert reload while a lookup is pending.
  - The pending result is delivered, then prog_ready=1 and lut_loaded=0.
  - After loading mem[i]=i+1, lookup 5 returns 6.
- **Reset mid-load:** drive rst low after 100 writes.
  - All outputs take their reset values, and wptr restarts at 0.
  - A full reload then works correctly.
- **Ignored programming:** drive prog_valid with 0xAA during LUT_RUN.
  - prog_ready stays 0 and table contents are unchanged; lookup 3 still returns the programmed value.
